pc_sequencer: RTL and testbench

- Registered program-counter unit for the MIPS core.
- Each cycle it picks the next PC from a priority-encoded set of NREDIR redirect channels, a captured pending redirect, or sequential PC+INSTR_BYTES.
- Adds what the combinational PC mux lacks: stall hold, capture of redirects that arrive during a stall or halt, a HALT/RUN state machine for debug control, and a one-cycle redirect strobe for the fetch flush logic.
- Sits between the IF-stage instruction-memory address and the branch/jump/JALR resolution paths.

---
 rtl/pc_sequencer_pkg.sv | 19 +
 rtl/pc_sequencer_prio_enc.sv | 29 ++
 rtl/pc_sequencer.sv | 134 +++++++++++++
 tb/tb_pc_sequencer.sv | 206 ++++++++++++++++++++
 4 files changed

// File: rtl/pc_sequencer_pkg.sv
// Shared types and constants for the program-counter sequencer.
// Channel indices follow the suggested redirect map; lower index wins.
package pc_sequencer_pkg;

  typedef enum logic {
    ST_RUN    = 1'b0,
    ST_HALTED = 1'b1
  } seq_state_e;

  localparam int REDIR_JALR   = 0;
  localparam int REDIR_JUMP   = 1;
  localparam int REDIR_BRANCH = 2;
  localparam int REDIR_EXC    = 3;

  function automatic int idx_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/pc_sequencer_prio_enc.sv
// Fixed-priority encoder over redirect requests: lowest set index wins and
// its slice of the packed target bus is returned.
module redir_prio_enc #(
  parameter int NREQ  = 4,
  parameter int NBITS = 32,
  parameter int IW    = 2
) (
  input  logic [NREQ-1:0]       req,
  input  logic [NREQ*NBITS-1:0] data,
  output logic                  hit,
  output logic [IW-1:0]         idx,
  output logic [NBITS-1:0]      sel
);

  // Walk from the top down so the lowest requesting index is written last.
  always_comb begin
    hit = 1'b0;
    idx = '0;
    sel = '0;
    for (int k = NREQ - 1; k >= 0; k--) begin
      if (req[k]) begin
        hit = 1'b1;
        idx = IW'(k);
        sel = data[k*NBITS +: NBITS];
      end
    end
  end

endmodule

// File: rtl/pc_sequencer.sv
// Registered PC unit: redirect priority, stall hold, pending-redirect capture
// and a RUN/HALTED debug state machine.
//
//   state     | meaning
//   ----------+---------------------------------------------------------
//   ST_RUN    | PC advances or redirects whenever i_stall is low
//   ST_HALTED | PC frozen; redirects are captured into pending
module pc_sequencer
  import pc_sequencer_pkg::*;
#(
  parameter int               NBITS       = 32,
  parameter int               NREDIR      = 4,
  parameter logic [NBITS-1:0] RESET_PC    = '0,
  parameter int               INSTR_BYTES = 4
) (
  input  logic                    i_clk,
  input  logic                    i_reset,
  input  logic [NREDIR-1:0]       i_redir_valid,
  input  logic [NREDIR*NBITS-1:0] i_redir_target,
  input  logic                    i_stall,
  input  logic                    i_halt,
  input  logic                    i_resume,
  output logic [NBITS-1:0]        o_pc,
  output logic [NBITS-1:0]        o_pc_plus4,
  output logic                    o_pc_valid,
  output logic                    o_redirect_taken,
  output logic                    o_pending,
  output logic                    o_halted
);

  localparam int IW = idx_width(NREDIR);

  seq_state_e       state, state_next;
  logic [NBITS-1:0] pc, pc_next;
  logic             taken, taken_next;
  logic             pend_valid, pend_valid_next;
  logic [IW-1:0]    pend_idx, pend_idx_next;
  logic [NBITS-1:0] pend_tgt, pend_tgt_next;

  logic             live_hit;
  logic [IW-1:0]    live_idx;
  logic [NBITS-1:0] live_tgt;
  logic [NREDIR-1:0] cap_req;
  logic             cap_hit;
  logic [IW-1:0]    cap_idx;
  logic [NBITS-1:0] cap_tgt;
  logic             advance;

  redir_prio_enc #(.NREQ(NREDIR), .NBITS(NBITS), .IW(IW)) u_live_enc (
    .req  (i_redir_valid),
    .data (i_redir_target),
    .hit  (live_hit),
    .idx  (live_idx),
    .sel  (live_tgt)
  );

  // Only channels that outrank the stored one may replace a held redirect;
  // with nothing held every channel is eligible.
  always_comb begin
    cap_req = '0;
    for (int k = 0; k < NREDIR; k++) begin
      cap_req[k] = i_redir_valid[k] && (!pend_valid || (k < int'(pend_idx)));
    end
  end

  redir_prio_enc #(.NREQ(NREDIR), .NBITS(NBITS), .IW(IW)) u_cap_enc (
    .req  (cap_req),
    .data (i_redir_target),
    .hit  (cap_hit),
    .idx  (cap_idx),
    .sel  (cap_tgt)
  );

  assign advance = (state == ST_RUN) && !i_stall;

  always_comb begin
    state_next      = state;
    pc_next         = pc;
    taken_next      = 1'b0;
    pend_valid_next = pend_valid;
    pend_idx_next   = pend_idx;
    pend_tgt_next   = pend_tgt;

    if (advance) begin
      if (live_hit) begin
        pc_next         = live_tgt;
        taken_next      = 1'b1;
        pend_valid_next = 1'b0;
      end else if (pend_valid) begin
        pc_next         = pend_tgt;
        taken_next      = 1'b1;
        pend_valid_next = 1'b0;
      end else begin
        pc_next = pc + NBITS'(INSTR_BYTES);
      end
    end else if (cap_hit) begin
      pend_valid_next = 1'b1;
      pend_idx_next   = cap_idx;
      pend_tgt_next   = cap_tgt;
    end

    case (state)
      ST_RUN:    if (i_halt) state_next = ST_HALTED;
      ST_HALTED: if (i_resume && !i_halt) state_next = ST_RUN;
      default:   state_next = ST_RUN;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      state      <= ST_RUN;
      pc         <= RESET_PC;
      taken      <= 1'b0;
      pend_valid <= 1'b0;
      pend_idx   <= '0;
      pend_tgt   <= '0;
    end else begin
      state      <= state_next;
      pc         <= pc_next;
      taken      <= taken_next;
      pend_valid <= pend_valid_next;
      pend_idx   <= pend_idx_next;
      pend_tgt   <= pend_tgt_next;
    end
  end

  assign o_pc             = pc;
  assign o_pc_plus4       = pc + NBITS'(INSTR_BYTES);
  assign o_pc_valid       = advance;
  assign o_redirect_taken = taken;
  assign o_pending        = pend_valid;
  assign o_halted         = (state == ST_HALTED);

endmodule

// File: tb/tb_pc_sequencer.sv
// Directed bench for pc_sequencer: stimulus pushes expected post-edge state
// into a queue tagged with its cycle; a negedge monitor pops and compares.
module tb_pc_sequencer;

  logic         clk = 1'b0;
  logic         reset;
  logic [3:0]   redir_valid;
  logic [127:0] redir_target;
  logic         stall, halt, resume;
  logic [31:0]  pc, pc_plus4;
  logic         pc_valid, redirect_taken, pending, halted;

  int checks = 0;
  int errors = 0;
  int cyc_cnt = 0;

  typedef struct {
    int          cyc;
    logic [31:0] pc;
    logic        tk;
    logic        pd;
    logic        hl;
  } exp_t;

  exp_t sb[$];

  pc_sequencer #(
    .NBITS(32), .NREDIR(4), .RESET_PC(32'h0000_0000), .INSTR_BYTES(4)
  ) dut (
    .i_clk            (clk),
    .i_reset          (reset),
    .i_redir_valid    (redir_valid),
    .i_redir_target   (redir_target),
    .i_stall          (stall),
    .i_halt           (halt),
    .i_resume         (resume),
    .o_pc             (pc),
    .o_pc_plus4       (pc_plus4),
    .o_pc_valid       (pc_valid),
    .o_redirect_taken (redirect_taken),
    .o_pending        (pending),
    .o_halted         (halted)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc_cnt <= cyc_cnt + 1;

  // Monitor
  always @(negedge clk) begin
    while (sb.size() > 0 && sb[0].cyc < cyc_cnt) begin
      checks++; errors++;
      $display("FAIL missed_entry cyc=%0d now=%0d", sb[0].cyc, cyc_cnt);
      void'(sb.pop_front());
    end
    if (sb.size() > 0 && sb[0].cyc == cyc_cnt) begin
      exp_t e;
      e = sb.pop_front();
      checks++;
      if (pc !== e.pc) begin
        errors++;
        $display("FAIL pc cyc=%0d got=%h exp=%h", e.cyc, pc, e.pc);
      end
      checks++;
      if (pc_plus4 !== e.pc + 32'd4) begin
        errors++;
        $display("FAIL pc_plus4 cyc=%0d got=%h exp=%h", e.cyc, pc_plus4, e.pc + 32'd4);
      end
      checks++;
      if (redirect_taken !== e.tk) begin
        errors++;
        $display("FAIL redirect_taken cyc=%0d got=%b exp=%b", e.cyc, redirect_taken, e.tk);
      end
      checks++;
      if (pending !== e.pd) begin
        errors++;
        $display("FAIL pending cyc=%0d got=%b exp=%b", e.cyc, pending, e.pd);
      end
      checks++;
      if (halted !== e.hl) begin
        errors++;
        $display("FAIL halted cyc=%0d got=%b exp=%b", e.cyc, halted, e.hl);
      end
    end
  end

  task automatic set_t(input int k, input logic [31:0] v);
    redir_target[k*32 +: 32] = v;
  endtask

  // Drive one cycle of inputs, check the combinational valid, and queue the
  // state expected right after the coming edge.
  task automatic step(input logic [3:0] rv, input logic st, input logic hl_in,
                      input logic rs, input logic rst, input logic ev,
                      input logic [31:0] epc, input logic etk,
                      input logic epd, input logic ehl);
    exp_t e;
    redir_valid = rv;
    stall       = st;
    halt        = hl_in;
    resume      = rs;
    reset       = rst;
    e.cyc = cyc_cnt + 1;
    e.pc  = epc;
    e.tk  = etk;
    e.pd  = epd;
    e.hl  = ehl;
    sb.push_back(e);
    #1;
    if (!rst) begin
      checks++;
      if (pc_valid !== ev) begin
        errors++;
        $display("FAIL pc_valid cyc=%0d got=%b exp=%b", cyc_cnt, pc_valid, ev);
      end
    end
    @(posedge clk);
    #1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog timeout");
    $display("CHECKS %0d ERRORS %0d", checks, errors + 1);
    $fatal(1);
  end

  initial begin
    redir_target = '0;
    //    rv     st hl rs rst ev  pc            tk pd hl
    step(4'b0000, 0, 0, 0, 1, 0, 32'h0000_0000, 0, 0, 0);
    step(4'b0000, 0, 0, 0, 0, 1, 32'h0000_0004, 0, 0, 0);
    step(4'b0000, 0, 0, 0, 0, 1, 32'h0000_0008, 0, 0, 0);
    step(4'b0000, 0, 0, 0, 0, 1, 32'h0000_000C, 0, 0, 0);
    step(4'b0000, 0, 0, 0, 0, 1, 32'h0000_0010, 0, 0, 0);

    // two live channels, ch1 outranks ch2
    set_t(1, 32'h200); set_t(2, 32'h300);
    step(4'b0110, 0, 0, 0, 0, 1, 32'h0000_0200, 1, 0, 0);
    step(4'b0000, 0, 0, 0, 0, 1, 32'h0000_0204, 0, 0, 0);

    // stall capture: ch2 then higher-priority ch0 replaces it
    set_t(0, 32'h40);
    step(4'b0001, 0, 0, 0, 0, 1, 32'h0000_0040, 1, 0, 0);
    set_t(2, 32'h80);
    step(4'b0100, 1, 0, 0, 0, 0, 32'h0000_0040, 0, 1, 0);
    set_t(0, 32'h100);
    step(4'b0001, 1, 0, 0, 0, 0, 32'h0000_0040, 0, 1, 0);
    step(4'b0000, 1, 0, 0, 0, 0, 32'h0000_0040, 0, 1, 0);
    step(4'b0000, 0, 0, 0, 0, 1, 32'h0000_0100, 1, 0, 0);
    step(4'b0000, 0, 0, 0, 0, 1, 32'h0000_0104, 0, 0, 0);

    // lower-priority channel must not replace a held ch1 redirect
    set_t(1, 32'h500); set_t(3, 32'h600);
    step(4'b0010, 1, 0, 0, 0, 0, 32'h0000_0104, 0, 1, 0);
    step(4'b1000, 1, 0, 0, 0, 0, 32'h0000_0104, 0, 1, 0);
    step(4'b0000, 0, 0, 0, 0, 1, 32'h0000_0500, 1, 0, 0);
    step(4'b0000, 0, 0, 0, 0, 1, 32'h0000_0504, 0, 0, 0);

    // live hit on release overrides and clears pending
    set_t(2, 32'h700); set_t(3, 32'h800);
    step(4'b0100, 1, 0, 0, 0, 0, 32'h0000_0504, 0, 1, 0);
    step(4'b1000, 0, 0, 0, 0, 1, 32'h0000_0800, 1, 0, 0);
    step(4'b0000, 0, 0, 0, 0, 1, 32'h0000_0804, 0, 0, 0);

    // halt at 0x20: the halting edge still advances, then PC freezes
    set_t(1, 32'h20);
    step(4'b0010, 0, 0, 0, 0, 1, 32'h0000_0020, 1, 0, 0);
    step(4'b0000, 0, 1, 0, 0, 1, 32'h0000_0024, 0, 0, 1);
    set_t(3, 32'h180);
    step(4'b1000, 0, 0, 0, 0, 0, 32'h0000_0024, 0, 1, 1);
    step(4'b0000, 0, 0, 0, 0, 0, 32'h0000_0024, 0, 1, 1);
    step(4'b0000, 0, 0, 1, 0, 0, 32'h0000_0024, 0, 1, 0);
    step(4'b0000, 0, 0, 0, 0, 1, 32'h0000_0180, 1, 0, 0);
    step(4'b0000, 0, 0, 0, 0, 1, 32'h0000_0184, 0, 0, 0);

    // halt and resume together: halt wins
    step(4'b0000, 0, 1, 1, 0, 1, 32'h0000_0188, 0, 0, 1);
    step(4'b0000, 0, 1, 1, 0, 0, 32'h0000_0188, 0, 0, 1);
    step(4'b0000, 0, 0, 0, 0, 0, 32'h0000_0188, 0, 0, 1);

    // reset while halted with a pending redirect
    set_t(2, 32'h900);
    step(4'b0100, 0, 0, 0, 0, 0, 32'h0000_0188, 0, 1, 1);
    step(4'b0000, 0, 0, 0, 1, 0, 32'h0000_0000, 0, 0, 0);
    step(4'b0000, 0, 0, 0, 0, 1, 32'h0000_0004, 0, 0, 0);

    // sequential wrap at the top of the address space
    set_t(0, 32'hFFFF_FFFC);
    step(4'b0001, 0, 0, 0, 0, 1, 32'hFFFF_FFFC, 1, 0, 0);
    step(4'b0000, 0, 0, 0, 0, 1, 32'h0000_0000, 0, 0, 0);
    step(4'b0000, 0, 0, 0, 0, 1, 32'h0000_0004, 0, 0, 0);

    redir_valid = '0;
    stall = 1'b0; halt = 1'b0; resume = 1'b0; reset = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_drain left=%0d exp=0", sb.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
